// File: rtl/ext_rom_pkg.sv
// Shared constants, read-FSM state encoding and window-decode helper for the
// external 2 KB ROM port.
package ext_rom_pkg;

  localparam int ROM_AW    = 11;
  localparam int ROM_BYTES = 2048;

  localparam logic [ROM_AW-1:0] ROM_LAST_ADDR = ROM_AW'(ROM_BYTES - 1);

  typedef enum logic [2:0] {
    R_IDLE = 3'd0,
    R_ADDR = 3'd1,
    R_CAP  = 3'd2,
    R_HOLD = 3'd3,
    R_WAIT = 3'd4
  } rd_state_e;

  // The window is 2 KB aligned, so only the upper five address bits decode it.
  function automatic logic rom_window_hit(input logic [15:0] addr,
                                          input logic [15:0] base);
    return addr[15:11] == base[15:11];
  endfunction

endpackage

// File: rtl/ext_rom_port_if.sv
// Loader-side bundle: byte stream in, BRAM port B write strobes out.
interface ext_rom_port_if;
  import ext_rom_pkg::*;

  // Handshake: a byte moves on every rising edge where ld_valid and ld_ready
  // are both high; ld_ready is registered and only changes on clock edges,
  // ld_start overrides the handshake for the cycle it is high.
  logic              ld_start;
  logic              ld_valid;
  logic [7:0]        ld_data;
  logic              ld_ready;
  logic              ld_done;
  logic [ROM_AW-1:0] rom_adb;
  logic [7:0]        rom_dinb;
  logic              rom_ceb;
  logic              rom_wreb;

  modport master (
    output ld_start, ld_valid, ld_data,
    input  ld_ready, ld_done, rom_adb, rom_dinb, rom_ceb, rom_wreb
  );

  modport slave (
    input  ld_start, ld_valid, ld_data,
    output ld_ready, ld_done, rom_adb, rom_dinb, rom_ceb, rom_wreb
  );

endinterface

// File: rtl/ext_rom_loader.sv
// Streams a 2048-byte image into BRAM port B; built only with EXT_ROM_LOADER_EN.
module ext_rom_loader
  import ext_rom_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  ext_rom_port_if.slave  ld
);

  logic [ROM_AW-1:0] ptr;
  logic              ready_q;
  logic              done_q;
  logic              ceb_q;
  logic              wreb_q;
  logic [ROM_AW-1:0] adb_q;
  logic [7:0]        dinb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      ceb_q   <= 1'b0;
      wreb_q  <= 1'b0;
      adb_q   <= '0;
      dinb_q  <= 8'h00;
    end else begin
      ceb_q  <= 1'b0;
      wreb_q <= 1'b0;
      // A start pulse restarts the image and swallows any coincident byte.
      if (ld.ld_start) begin
        ptr     <= '0;
        ready_q <= 1'b1;
        done_q  <= 1'b0;
      end else if (ld.ld_valid && ready_q) begin
        ceb_q  <= 1'b1;
        wreb_q <= 1'b1;
        adb_q  <= ptr;
        dinb_q <= ld.ld_data;
        ptr    <= ptr + 1'b1;
        if (ptr == ROM_LAST_ADDR) begin
          ready_q <= 1'b0;
          done_q  <= 1'b1;
        end
      end
    end
  end

  assign ld.ld_ready = ready_q;
  assign ld.ld_done  = done_q;
  assign ld.rom_ceb  = ceb_q;
  assign ld.rom_wreb = wreb_q;
  assign ld.rom_adb  = adb_q;
  assign ld.rom_dinb = dinb_q;

endmodule

// File: rtl/ext_rom_port.sv
// Z80 read overlay for a 2 KB BRAM ROM window plus optional image loader
// (loader compiled in when EXT_ROM_LOADER_EN is defined).
module ext_rom_port
  import ext_rom_pkg::*;
#(
  parameter logic [15:0] ROM_BASE = 16'h0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rom_en,
  input  logic [15:0]       z80_addr,
  input  logic              z80_mreq_n,
  input  logic              z80_rd_n,
  output logic [7:0]        z80_dout,
  output logic              z80_oe,
  output logic [ROM_AW-1:0] rom_ada,
  output logic              rom_cea,
  output logic              rom_ocea,
  input  logic [7:0]        rom_douta,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  output logic              ld_ready,
  output logic              ld_done,
  output logic [ROM_AW-1:0] rom_adb,
  output logic [7:0]        rom_dinb,
  output logic              rom_ceb,
  output logic              rom_wreb
);

  rd_state_e state;
  rd_state_e state_nxt;
  logic      rd_req;
  logic      hit;
  logic      load_busy;

  assign rd_req = !z80_mreq_n && !z80_rd_n;
  assign hit    = rd_req && rom_en && !load_busy && rom_window_hit(z80_addr, ROM_BASE);

  // Strobe loss before R_HOLD abandons the access without driving the bus.
  always_comb begin
    state_nxt = state;
    case (state)
      R_IDLE: begin
        if (hit)         state_nxt = R_ADDR;
        else if (rd_req) state_nxt = R_WAIT;
      end
      R_ADDR:  state_nxt = rd_req ? R_CAP  : R_IDLE;
      R_CAP:   state_nxt = rd_req ? R_HOLD : R_IDLE;
      R_HOLD:  if (!rd_req) state_nxt = R_IDLE;
      R_WAIT:  if (!rd_req) state_nxt = R_IDLE;
      default: state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= R_IDLE;
      rom_cea  <= 1'b0;
      rom_ada  <= '0;
      z80_dout <= 8'h00;
    end else begin
      state   <= state_nxt;
      rom_cea <= (state == R_IDLE) && hit;
      if ((state == R_IDLE) && hit) rom_ada <= z80_addr[ROM_AW-1:0];
      if ((state == R_CAP) && rd_req) z80_dout <= rom_douta;
    end
  end

  assign z80_oe   = (state == R_HOLD);
  assign rom_ocea = 1'b1;

`ifdef EXT_ROM_LOADER_EN
  ext_rom_port_if ld_bus ();

  assign ld_bus.ld_start = ld_start;
  assign ld_bus.ld_valid = ld_valid;
  assign ld_bus.ld_data  = ld_data;

  ext_rom_loader u_loader (
    .clk   (clk),
    .rst_n (rst_n),
    .ld    (ld_bus)
  );

  assign ld_ready  = ld_bus.ld_ready;
  assign ld_done   = ld_bus.ld_done;
  assign rom_adb   = ld_bus.rom_adb;
  assign rom_dinb  = ld_bus.rom_dinb;
  assign rom_ceb   = ld_bus.rom_ceb;
  assign rom_wreb  = ld_bus.rom_wreb;
  assign load_busy = ld_bus.ld_ready;
`else
  // Without a loader the ROM keeps its initialized content and is always "loaded".
  logic done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done_q <= 1'b0;
    else        done_q <= 1'b1;
  end

  logic unused_ld;
  assign unused_ld = &{1'b0, ld_start, ld_valid, ld_data};

  assign ld_ready  = 1'b0;
  assign ld_done   = done_q;
  assign rom_adb   = '0;
  assign rom_dinb  = 8'h00;
  assign rom_ceb   = 1'b0;
  assign rom_wreb  = 1'b0;
  assign load_busy = 1'b0;
`endif

endmodule

// File: tb/tb_ext_rom_port.sv
// Bench for ext_rom_port: table-driven Z80 reads, abort/reset sequences and,
// when EXT_ROM_LOADER_EN is defined, a full image load through port B.
module tb_ext_rom_port;
  import ext_rom_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic              rom_en;
  logic [15:0]       z80_addr;
  logic              z80_mreq_n;
  logic              z80_rd_n;
  logic [7:0]        z80_dout;
  logic              z80_oe;
  logic [ROM_AW-1:0] rom_ada;
  logic              rom_cea;
  logic              rom_ocea;
  logic [7:0]        rom_douta;

  ext_rom_port_if ldif ();

  ext_rom_port #(.ROM_BASE(16'h0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rom_en     (rom_en),
    .z80_addr   (z80_addr),
    .z80_mreq_n (z80_mreq_n),
    .z80_rd_n   (z80_rd_n),
    .z80_dout   (z80_dout),
    .z80_oe     (z80_oe),
    .rom_ada    (rom_ada),
    .rom_cea    (rom_cea),
    .rom_ocea   (rom_ocea),
    .rom_douta  (rom_douta),
    .ld_start   (ldif.ld_start),
    .ld_valid   (ldif.ld_valid),
    .ld_data    (ldif.ld_data),
    .ld_ready   (ldif.ld_ready),
    .ld_done    (ldif.ld_done),
    .rom_adb    (ldif.rom_adb),
    .rom_dinb   (ldif.rom_dinb),
    .rom_ceb    (ldif.rom_ceb),
    .rom_wreb   (ldif.rom_wreb)
  );

  // ---------------- BRAM model ----------------
  logic [7:0] mem [ROM_BYTES];

  function automatic logic [7:0] init_val(input int a);
    int v;
    v = a * 7 + 3;
    if (a == 5) return 8'hF3;
    return v[7:0];
  endfunction

  always @(posedge clk) begin
    if (rom_cea) rom_douta <= mem[rom_ada];
    if (ldif.rom_ceb && ldif.rom_wreb) mem[ldif.rom_adb] <= ldif.rom_dinb;
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [ROM_AW-1:0] a;
    logic [7:0]        d;
  } wr_t;

  logic [7:0] exp_q[$];
  wr_t        wr_q[$];
  int         cea_cnt  = 0;
  int         wreb_cnt = 0;
  int         cea_base = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rom_cea) cea_cnt++;
    if (ldif.rom_wreb) begin
      wr_t e;
      wreb_cnt++;
      check("wr_ceb", 32'(ldif.rom_ceb), 32'd1);
      if (wr_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL wr_unexpected: write addr %0h data %0h, expected no write",
                 ldif.rom_adb, ldif.rom_dinb);
      end else begin
        e = wr_q.pop_front();
        check("wr_addr", 32'(ldif.rom_adb), 32'(e.a));
        check("wr_data", 32'(ldif.rom_dinb), 32'(e.d));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_outputs(input string tag);
    check({tag, "_oe"},       32'(z80_oe),        32'd0);
    check({tag, "_dout"},     32'(z80_dout),      32'd0);
    check({tag, "_cea"},      32'(rom_cea),       32'd0);
    check({tag, "_ada"},      32'(rom_ada),       32'd0);
    check({tag, "_ceb"},      32'(ldif.rom_ceb),  32'd0);
    check({tag, "_wreb"},     32'(ldif.rom_wreb), 32'd0);
    check({tag, "_adb"},      32'(ldif.rom_adb),  32'd0);
    check({tag, "_dinb"},     32'(ldif.rom_dinb), 32'd0);
    check({tag, "_ld_ready"}, 32'(ldif.ld_ready), 32'd0);
    check({tag, "_ld_done"},  32'(ldif.ld_done),  32'd0);
  endtask

  // Drives a read strobe and walks the R_ADDR / R_CAP / R_HOLD timing.
  task automatic start_read(input logic [15:0] addr, input bit en, input bit hit,
                            input logic [7:0] data, input bit drop_en);
    @(negedge clk);
    z80_addr   = addr;
    rom_en     = en;
    z80_mreq_n = 1'b0;
    z80_rd_n   = 1'b0;
    cea_base   = cea_cnt;
    if (hit) exp_q.push_back(data);
    @(negedge clk);
    check("cea_first", 32'(rom_cea), 32'(hit));
    if (hit) check("rom_ada", 32'(rom_ada), 32'(addr[ROM_AW-1:0]));
    check("oe_cyc1", 32'(z80_oe), 32'd0);
    if (drop_en) rom_en = 1'b0;
    @(negedge clk);
    check("cea_once", 32'(rom_cea), 32'd0);
    check("oe_cyc2", 32'(z80_oe), 32'd0);
    @(negedge clk);
    check("oe_cyc3", 32'(z80_oe), 32'(hit));
    if (hit) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL dout_queue: got %0h, expected queued value", z80_dout);
      end else begin
        check("z80_dout", 32'(z80_dout), 32'(exp_q.pop_front()));
      end
    end
  endtask

  task automatic end_read(input bit via_mreq, input bit hit);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("oe_hold", 32'(z80_oe), 32'(hit));
    end
    if (via_mreq) z80_mreq_n = 1'b1;
    else          z80_rd_n   = 1'b1;
    @(negedge clk);
    check("oe_release", 32'(z80_oe), 32'd0);
    check("cea_count", 32'(cea_cnt - cea_base), 32'(hit));
    z80_mreq_n = 1'b1;
    z80_rd_n   = 1'b1;
    rom_en     = 1'b1;
  endtask

  // Strobe held for `edges` rising edges then dropped; the bus must never be driven.
  task automatic short_read(input logic [15:0] addr, input int edges);
    @(negedge clk);
    z80_addr   = addr;
    z80_mreq_n = 1'b0;
    z80_rd_n   = 1'b0;
    cea_base   = cea_cnt;
    repeat (edges) @(negedge clk);
    z80_rd_n   = 1'b1;
    z80_mreq_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("short_oe", 32'(z80_oe), 32'd0);
    end
    check("short_cea", 32'(cea_cnt - cea_base), 32'd1);
  endtask

  task automatic stream(input int start_idx, input int n);
    int idx;
    int guard;
    idx   = start_idx;
    guard = 0;
    while (idx < start_idx + n && guard < 20000) begin
      @(negedge clk);
      guard++;
      if ($urandom_range(0, 3) == 0) begin
        ldif.ld_valid = 1'b0;
      end else begin
        ldif.ld_valid = 1'b1;
        ldif.ld_data  = 8'(idx);
        if (ldif.ld_ready) begin
          wr_q.push_back('{a: ROM_AW'(idx), d: 8'(idx)});
          idx++;
        end
      end
    end
    @(negedge clk);
    ldif.ld_valid = 1'b0;
    check("stream_progress", 32'(idx), 32'(start_idx + n));
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [15:0] addr;
    bit          en;
    bit          hit;
    logic [7:0]  data;
    bit          via_mreq;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'h0005, 1'b1, 1'b1, 8'hF3, 1'b0};
    vecs[1] = '{16'h0800, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[2] = '{16'h0005, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[3] = '{16'h0000, 1'b1, 1'b1, 8'h03, 1'b1};
    vecs[4] = '{16'h07FF, 1'b1, 1'b1, 8'hFC, 1'b0};
    vecs[5] = '{16'h0123, 1'b1, 1'b1, 8'hF8, 1'b1};
    vecs[6] = '{16'hF805, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[7] = '{16'h4000, 1'b1, 1'b0, 8'h00, 1'b1};

    for (int i = 0; i < ROM_BYTES; i++) mem[i] = init_val(i);

    rst_n         = 1'b0;
    rom_en        = 1'b1;
    z80_addr      = 16'h0000;
    z80_mreq_n    = 1'b1;
    z80_rd_n      = 1'b1;
    ldif.ld_start = 1'b0;
    ldif.ld_valid = 1'b0;
    ldif.ld_data  = 8'h00;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    check("rom_ocea", 32'(rom_ocea), 32'd1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
`ifdef EXT_ROM_LOADER_EN
    check("post_reset_ld_done", 32'(ldif.ld_done), 32'd0);
`else
    check("post_reset_ld_done", 32'(ldif.ld_done), 32'd1);
`endif
    check("post_reset_ld_ready", 32'(ldif.ld_ready), 32'd0);

    for (int i = 0; i < 8; i++) begin
      start_read(vecs[i].addr, vecs[i].en, vecs[i].hit, vecs[i].data, 1'b0);
      end_read(vecs[i].via_mreq, vecs[i].hit);
    end

    // Strobe lost in R_ADDR, then in R_CAP.
    short_read(16'h0005, 1);
    short_read(16'h0005, 2);

    // rom_en falling after the hit does not cancel the access.
    start_read(16'h0010, 1'b1, 1'b1, 8'h73, 1'b1);
    end_read(1'b0, 1'b1);

    // A miss parks in R_WAIT; retargeting the held strobe must not service it.
    @(negedge clk);
    z80_addr   = 16'h0900;
    z80_mreq_n = 1'b0;
    z80_rd_n   = 1'b0;
    cea_base   = cea_cnt;
    repeat (2) @(negedge clk);
    z80_addr = 16'h0005;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("wait_oe", 32'(z80_oe), 32'd0);
    end
    check("wait_cea", 32'(cea_cnt - cea_base), 32'd0);
    z80_mreq_n = 1'b1;
    z80_rd_n   = 1'b1;
    @(negedge clk);

    // Reset asserted while the bus is being driven.
    start_read(16'h0005, 1'b1, 1'b1, 8'hF3, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_hold");
    z80_mreq_n = 1'b1;
    z80_rd_n   = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

`ifdef EXT_ROM_LOADER_EN
    // ld_start arriving during R_HOLD leaves the captured byte on the bus.
    start_read(16'h0005, 1'b1, 1'b1, 8'hF3, 1'b0);
    ldif.ld_start = 1'b1;
    @(negedge clk);
    ldif.ld_start = 1'b0;
    check("hold_keep_oe", 32'(z80_oe), 32'd1);
    check("hold_keep_dout", 32'(z80_dout), 32'hF3);
    check("start_ready", 32'(ldif.ld_ready), 32'd1);
    check("start_done", 32'(ldif.ld_done), 32'd0);
    end_read(1'b0, 1'b1);

    stream(0, 1000);
    start_read(16'h0005, 1'b1, 1'b0, 8'h00, 1'b0);
    end_read(1'b0, 1'b0);
    stream(1000, ROM_BYTES - 1000);
    repeat (2) @(negedge clk);
    check("load_done", 32'(ldif.ld_done), 32'd1);
    check("load_ready", 32'(ldif.ld_ready), 32'd0);
    check("load_writes", 32'(wreb_cnt), 32'(ROM_BYTES));
    check("load_wr_q_empty", 32'(wr_q.size()), 32'd0);

    // A 2049th byte must not be accepted.
    ldif.ld_valid = 1'b1;
    ldif.ld_data  = 8'hAA;
    repeat (3) @(negedge clk);
    ldif.ld_valid = 1'b0;
    check("extra_byte_writes", 32'(wreb_cnt), 32'(ROM_BYTES));

    start_read(16'h07FF, 1'b1, 1'b1, 8'hFF, 1'b0);
    end_read(1'b0, 1'b1);
    start_read(16'h0005, 1'b1, 1'b1, 8'h05, 1'b0);
    end_read(1'b1, 1'b1);

    // Start beats a coincident byte; pointer restarts at 0.
    @(negedge clk);
    ldif.ld_start = 1'b1;
    ldif.ld_valid = 1'b1;
    ldif.ld_data  = 8'h55;
    @(negedge clk);
    ldif.ld_start = 1'b0;
    ldif.ld_valid = 1'b0;
    check("restart_ready", 32'(ldif.ld_ready), 32'd1);
    check("restart_done", 32'(ldif.ld_done), 32'd0);
    stream(0, 100);

    // Reset mid-load with a byte offered: no further write may follow.
    ldif.ld_valid = 1'b1;
    ldif.ld_data  = 8'h77;
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_load");
    repeat (3) @(negedge clk);
    ldif.ld_valid = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_load_writes", 32'(wreb_cnt), 32'(ROM_BYTES + 100));
    check("rst_load_wr_q", 32'(wr_q.size()), 32'd0);
`else
    // Loader inputs are ignored and reads are never blocked.
    @(negedge clk);
    ldif.ld_start = 1'b1;
    ldif.ld_valid = 1'b1;
    ldif.ld_data  = 8'h5A;
    @(negedge clk);
    ldif.ld_start = 1'b0;
    repeat (3) @(negedge clk);
    ldif.ld_valid = 1'b0;
    check("noload_ready", 32'(ldif.ld_ready), 32'd0);
    check("noload_done", 32'(ldif.ld_done), 32'd1);
    start_read(16'h0000, 1'b1, 1'b1, 8'h03, 1'b0);
    end_read(1'b0, 1'b1);
    check("noload_writes", 32'(wreb_cnt), 32'd0);
`endif

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
